membank_arbiter: RTL and testbench
==================================

Name: membank_arbiter

Overview:
Two-requester controller for the node's 64-byte, 16-bit-word memory bank (single port: combinational read, byte-pair write on clk). It grants the bank to one requester at a time using round-robin, then runs a burst of 1..32 consecutive word accesses, stepping the byte index by 2. It sits between the bank and its clients, e.g. the packet receive path (A) and the Q-value/cluster-head update engine (B).

Parameters:
ADDR_W, 6, bank byte-index width (64 bytes)
DATA_W, 16, word width (two bank bytes)
LEN_W, 5, burst length field width; encodes words-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_a / req_b  in  1  transfer request; sampled only in IDLE
we_a / we_b  in  1  1 = write burst, 0 = read burst
base_a / base_b  in  ADDR_W  start byte index; bit 0 ignored
len_a / len_b  in  LEN_W  burst length minus one (0 -> 1 word, 31 -> 32 words)
wdata_a / wdata_b  in  DATA_W  write word; must be valid whenever gnt_x=1 and the burst is a write
wack_a / wack_b  out  1  write word consumed this cycle; requester advances wdata on the next edge
rdata_a / rdata_b  out  DATA_W  registered read word
rvalid_a / rvalid_b  out  1  rdata_x valid this cycle
gnt_a / gnt_b  out  1  high for the whole XFER phase of that requester
done_a / done_b  out  1  one-cycle burst-complete pulse
mem_wr_en  out  1  to bank wr_en
mem_index  out  ADDR_W  to bank index; always even
mem_data_in  out  DATA_W  to bank data_in
mem_data_out  in  DATA_W  from bank data_out (combinational)

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. Reset puts the FSM in IDLE and drives every output to 0: gnt, wack, rvalid, done, rdata, mem_wr_en, mem_index, mem_data_in. The last-served pointer resets to B, so A wins the first tie.
- FSM states: IDLE -> XFER -> DONE -> IDLE.
- IDLE:
  - If either req_x is high, choose the winner. If only one requests, it wins. If both request, the one not served last wins.
  - Latch the winner's we, base (with bit 0 forced to 0) and len into registers. Set the word count to len and go to XFER.
  - If no request, stay in IDLE.
- XFER (gnt_x=1), one word per cycle:
  - mem_index = current index register.
  - Write burst: mem_wr_en=1, mem_data_in=wdata_x, wack_x=1.
  - Read burst: mem_wr_en=0, and rdata_x <= mem_data_out registered, with rvalid_x=1 on the following cycle.
  - Each cycle the index increments by 2, modulo 64 (62 wraps to 0). The count decrements.
  - When the count is 0 during an access, that is the last word; the next state is DONE.
- DONE: gnt_x=0, done_x=1 for one cycle, mem_wr_en=0, then go to IDLE. The point is updated to x.
- Outside a write XFER, mem_wr_en=0 and mem_data_in=0. mem_index holds its last value.
- Timing (request seen in IDLE at cycle N):
  - Grant and first access at N+1.
  - Last access at N+1+len.
  - done_x at N+2+len.
  - For reads, rvalid for word k is at N+2+k, so the last rvalid coincides with done_x.
  - The next grant is earliest at N+4+len.
- A requester must drop req_x by the done cycle. If it is still high in IDLE, it is re-arbitrated and loses any tie.
- req or base/len changes during XFER are ignored; there is no abort.
- The other requester's outputs stay 0 throughout.
- rst asserted mid-burst: at that edge everything returns to the reset values. No done pulse is issued, and partially written words remain in the bank.

Decomposition:
- Shared package: ADDR_W, DATA_W and LEN_W defaults; FSM state encoding (IDLE, XFER, DONE); requester ID constants (RQ_A=0, RQ_B=1).
- One natural sub-module, rr_arbiter2: two requests plus the last-served pointer in, one-hot grant out. It is combinational, with the pointer update enabled by the DONE state.

Test Plan:
- Write: after reset, A write with base=4, len=2, data 0x1111/0x2222/0x3333 -> mem_index 4, 6, 8 with mem_wr_en and wack_a on 3 consecutive cycles; done_a one cycle later. Then an A read with the same base/len -> rdata_a 0x1111, 0x2222, 0x3333 with rvalid_a, the last coinciding with done_a.
- Fairness: req_a and req_b both held high, len=0 -> grant sequence A, B, A, B. Never two gnt high at once; gnt pulses 3 cycles apart.
- Wrap: B write with base=62, len=1, data 0xAAAA/0xBBBB -> mem_index 62 then 0. A read of base=0 returns 0xBBBB.
- Odd base: A read with base=5, len=0 -> mem_index=4; only even indices ever appear on mem_index.
- Reset mid-burst: A write with len=7, rst asserted on the 3rd access cycle -> after that edge gnt_a=0, mem_wr_en=0, no done_a. The next simultaneous request grants A.
- Full bank: B write of 32 words (len=31) with value index*0x0101, then a B read with len=31 -> 32 rvalid_b values matching, and mem_index covering 0..62 in order.

Source files
------------

// File: rtl/membank_arbiter_pkg.sv
// Shared widths, FSM encoding and requester IDs for the two-port memory bank arbiter.
package membank_arbiter_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic RQ_A = 1'b0;
  localparam logic RQ_B = 1'b1;

endpackage

// File: rtl/membank_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: one-hot grant {B, A}; the last-served pointer moves only on update.
module rr_arbiter2
  import membank_arbiter_pkg::*;
(
  input  logic       req_a_i,
  input  logic       req_b_i,
  input  logic       last_i,
  input  logic       upd_en_i,
  input  logic       served_i,
  output logic [1:0] gnt_o,
  output logic       last_d_o
);

  always_comb begin
    // NOTE: default first so every path assigns gnt_o and no latch is inferred.
    gnt_o = 2'b00;
    if (req_a_i && req_b_i) begin
      gnt_o = (last_i == RQ_B) ? 2'b01 : 2'b10;
    end else begin
      gnt_o = {req_b_i, req_a_i};
    end
  end

  assign last_d_o = upd_en_i ? served_i : last_i;

endmodule

// File: rtl/membank_arbiter.sv
// Round-robin owner of a single-port 16-bit bank: grants A or B a burst of 1..32 word accesses.
module membank_arbiter
  import membank_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [LEN_W-1:0]  len_a,
  input  logic [LEN_W-1:0]  len_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              wack_a,
  output logic              wack_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              done_a,
  output logic              done_b,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_index,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_e            state_q;
  logic              owner_q;
  logic              we_q;
  logic              last_q;
  logic              last_d;
  logic [ADDR_W-1:0] idx_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
  logic              rvalid_a_q, rvalid_b_q;
  logic [1:0]        arb_gnt;
  logic [ADDR_W-1:0] sel_base;

  rr_arbiter2 u_arb (
    .req_a_i  (req_a),
    .req_b_i  (req_b),
    .last_i   (last_q),
    .upd_en_i (state_q == S_DONE),
    .served_i (owner_q),
    .gnt_o    (arb_gnt),
    .last_d_o (last_d)
  );

  assign sel_base = arb_gnt[1] ? base_b : base_a;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= RQ_A;
      we_q       <= 1'b0;
      last_q     <= RQ_B;
      idx_q      <= '0;
      cnt_q      <= '0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arb_gnt != 2'b00) begin
            owner_q <= arb_gnt[1] ? RQ_B : RQ_A;
            we_q    <= arb_gnt[1] ? we_b : we_a;
            idx_q   <= sel_base & ~ADDR_W'(1);
            cnt_q   <= arb_gnt[1] ? len_b : len_a;
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          if (!we_q) begin
            if (owner_q == RQ_A) begin
              rdata_a_q  <= mem_data_out;
              rvalid_a_q <= 1'b1;
            end else begin
              rdata_b_q  <= mem_data_out;
              rvalid_b_q <= 1'b1;
            end
          end
          // The index stops on the last word so mem_index holds it through DONE and IDLE.
          if (cnt_q == '0) begin
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + ADDR_W'(2);
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_a       = (state_q == S_XFER) && (owner_q == RQ_A);
  assign gnt_b       = (state_q == S_XFER) && (owner_q == RQ_B);
  assign done_a      = (state_q == S_DONE) && (owner_q == RQ_A);
  assign done_b      = (state_q == S_DONE) && (owner_q == RQ_B);
  assign mem_wr_en   = (state_q == S_XFER) && we_q;
  assign wack_a      = mem_wr_en && (owner_q == RQ_A);
  assign wack_b      = mem_wr_en && (owner_q == RQ_B);
  assign mem_index   = idx_q;
  assign mem_data_in = !mem_wr_en ? '0 : ((owner_q == RQ_B) ? wdata_b : wdata_a);
  assign rdata_a     = rdata_a_q;
  assign rdata_b     = rdata_b_q;
  assign rvalid_a    = rvalid_a_q;
  assign rvalid_b    = rvalid_b_q;

endmodule

// File: tb/tb_membank_arbiter.sv
// Directed bench for membank_arbiter with a behavioural 32-word bank model attached to the mem_* port.
module tb_membank_arbiter;
  import membank_arbiter_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;
  localparam int LW = LEN_W_DEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a, req_b, we_a, we_b;
  logic [AW-1:0] base_a, base_b;
  logic [LW-1:0] len_a, len_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          wack_a, wack_b, rvalid_a, rvalid_b;
  logic          gnt_a, gnt_b, done_a, done_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          mem_wr_en;
  logic [AW-1:0] mem_index;
  logic [DW-1:0] mem_data_in, mem_data_out;

  logic [DW-1:0] bank [32];
  logic [DW-1:0] wv [3] = '{16'h1111, 16'h2222, 16'h3333};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  membank_arbiter dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .base_a(base_a), .base_b(base_b), .len_a(len_a), .len_b(len_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .wack_a(wack_a), .wack_b(wack_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .mem_wr_en(mem_wr_en), .mem_index(mem_index),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always @(posedge clk) if (mem_wr_en) bank[mem_index[5:1]] <= mem_data_in;
  assign mem_data_out = bank[mem_index[5:1]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Invariants sampled mid-cycle: never two grants, never an odd bank index.
  always @(negedge clk) begin
    if (!rst) begin
      check("gnt_onehot", 32'(gnt_a & gnt_b), 32'd0);
      check("even_index", 32'(mem_index[0]), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    base_a = '0; base_b = '0; len_a = '0; len_b = '0;
    wdata_a = '0; wdata_b = '0;
    step();
    step();
    #1;
    check("rst_gnt",      32'({gnt_a, gnt_b}), 32'd0);
    check("rst_done",     32'({done_a, done_b}), 32'd0);
    check("rst_wack",     32'({wack_a, wack_b}), 32'd0);
    check("rst_rvalid",   32'({rvalid_a, rvalid_b}), 32'd0);
    check("rst_rdata_a",  32'(rdata_a), 32'd0);
    check("rst_rdata_b",  32'(rdata_b), 32'd0);
    check("rst_wr_en",    32'(mem_wr_en), 32'd0);
    check("rst_index",    32'(mem_index), 32'd0);
    check("rst_data_in",  32'(mem_data_in), 32'd0);
    rst = 1'b0;

    // Fairness: both held, len 0 -> A, B, A, B, three cycles apart.
    step();
    req_a = 1'b1; req_b = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      check("fair_gnt_a",  32'(gnt_a),  32'(c == 1 || c == 7));
      check("fair_gnt_b",  32'(gnt_b),  32'(c == 4 || c == 10));
      check("fair_done_a", 32'(done_a), 32'(c == 2 || c == 8));
      check("fair_done_b", 32'(done_b), 32'(c == 5 || c == 11));
      if (c == 11) begin
        req_a = 1'b0; req_b = 1'b0;
      end
    end

    // A write base 4, len 2.
    step();
    req_a = 1'b1; we_a = 1'b1; base_a = 6'd4; len_a = 5'd2; wdata_a = wv[0];
    #1;
    check("wr_idle_gnt", 32'(gnt_a), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 0) req_a = 1'b0;
      wdata_a = wv[k];
      #1;
      check("wr_gnt_a",   32'(gnt_a), 32'd1);
      check("wr_wr_en",   32'(mem_wr_en), 32'd1);
      check("wr_wack_a",  32'(wack_a), 32'd1);
      check("wr_index",   32'(mem_index), 32'(4 + 2 * k));
      check("wr_data_in", 32'(mem_data_in), 32'(wv[k]));
    end
    step();
    check("wr_done_a",    32'(done_a), 32'd1);
    check("wr_done_gnt",  32'(gnt_a), 32'd0);
    check("wr_done_wren", 32'(mem_wr_en), 32'd0);
    check("wr_done_idx",  32'(mem_index), 32'd8);
    check("wr_done_din",  32'(mem_data_in), 32'd0);

    // A read back the same range.
    step();
    req_a = 1'b1; we_a = 1'b0;
    #1;
    check("rd_idle_done", 32'(done_a), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 0) req_a = 1'b0;
      check("rd_gnt_a",   32'(gnt_a), 32'd1);
      check("rd_wr_en",   32'(mem_wr_en), 32'd0);
      check("rd_wack_a",  32'(wack_a), 32'd0);
      check("rd_index",   32'(mem_index), 32'(4 + 2 * k));
      check("rd_rvalid",  32'(rvalid_a), 32'(k > 0));
      if (k > 0) check("rd_rdata", 32'(rdata_a), 32'(wv[k-1]));
    end
    step();
    check("rd_done_a",    32'(done_a), 32'd1);
    check("rd_last_rval", 32'(rvalid_a), 32'd1);
    check("rd_last_data", 32'(rdata_a), 32'h3333);

    // Wrap: B write base 62, len 1.
    step();
    req_b = 1'b1; we_b = 1'b1; base_b = 6'd62; len_b = 5'd1; wdata_b = 16'hAAAA;
    step();
    req_b = 1'b0;
    #1;
    check("wrap_idx0",  32'(mem_index), 32'd62);
    check("wrap_wack0", 32'(wack_b), 32'd1);
    check("wrap_gnt_a", 32'(gnt_a), 32'd0);
    step();
    wdata_b = 16'hBBBB;
    #1;
    check("wrap_idx1",  32'(mem_index), 32'd0);
    check("wrap_din1",  32'(mem_data_in), 32'hBBBB);
    step();
    check("wrap_done_b", 32'(done_b), 32'd1);
    step();
    req_a = 1'b1; we_a = 1'b0; base_a = 6'd0; len_a = 5'd0;
    step();
    req_a = 1'b0;
    #1;
    check("wrap_rd_idx", 32'(mem_index), 32'd0);
    step();
    check("wrap_rd_done", 32'(done_a), 32'd1);
    check("wrap_rd_val",  32'(rvalid_a), 32'd1);
    check("wrap_rd_data", 32'(rdata_a), 32'hBBBB);

    // Odd base 5 is forced down to 4.
    step();
    req_a = 1'b1; base_a = 6'd5; len_a = 5'd0;
    step();
    req_a = 1'b0;
    #1;
    check("odd_idx",  32'(mem_index), 32'd4);
    check("odd_gnt",  32'(gnt_a), 32'd1);
    step();
    check("odd_data", 32'(rdata_a), 32'h1111);
    check("odd_done", 32'(done_a), 32'd1);

    // Reset on the third access of an 8-word write.
    step();
    req_a = 1'b1; we_a = 1'b1; base_a = 6'd10; len_a = 5'd7; wdata_a = 16'h5A00;
    step();
    req_a = 1'b0;
    step();
    wdata_a = 16'h5A01;
    step();
    wdata_a = 16'h5A02;
    #1;
    check("rstm_gnt_pre", 32'(gnt_a), 32'd1);
    check("rstm_idx_pre", 32'(mem_index), 32'd14);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0;
    len_a = 5'd0; len_b = 5'd0; base_b = 6'd0;
    #1;
    check("rstm_gnt_a",  32'(gnt_a), 32'd0);
    check("rstm_wr_en",  32'(mem_wr_en), 32'd0);
    check("rstm_done_a", 32'(done_a), 32'd0);
    check("rstm_index",  32'(mem_index), 32'd0);
    step();
    req_a = 1'b0; req_b = 1'b0;
    #1;
    check("rstm_tie_a",  32'(gnt_a), 32'd1);
    check("rstm_tie_b",  32'(gnt_b), 32'd0);
    check("rstm_nodone", 32'(done_a), 32'd0);
    step();
    check("rstm_done2",  32'(done_a), 32'd1);

    // Full bank: B writes 32 words of k*0x0101 from 0, then reads them back.
    step();
    req_b = 1'b1; we_b = 1'b1; base_b = 6'd0; len_b = 5'd31; wdata_b = '0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (k == 0) req_b = 1'b0;
      wdata_b = 16'(k) * 16'h0101;
      #1;
      check("full_wr_idx",  32'(mem_index), 32'(2 * k));
      check("full_wr_wack", 32'(wack_b), 32'd1);
      check("full_wr_gnta", 32'(gnt_a), 32'd0);
    end
    step();
    check("full_wr_done", 32'(done_b), 32'd1);
    step();
    req_b = 1'b1; we_b = 1'b0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (k == 0) req_b = 1'b0;
      check("full_rd_idx", 32'(mem_index), 32'(2 * k));
      check("full_rd_val", 32'(rvalid_b), 32'(k > 0));
      if (k > 0) check("full_rd_data", 32'(rdata_b), 32'(16'(k - 1) * 16'h0101));
      check("full_rd_rva", 32'(rvalid_a), 32'd0);
    end
    step();
    check("full_rd_done", 32'(done_b), 32'd1);
    check("full_rd_lval", 32'(rvalid_b), 32'd1);
    check("full_rd_last", 32'(rdata_b), 32'h1F1F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
